datapath_control: RTL and testbench
===================================

DATAPATH_CONTROL -- requirements
Module: datapath_control

Interface
REQ-001 SHALL have parameter QW, default 16, meaning width of quotient counter and iteration limit.
REQ-002 SHALL have parameter MAX_ITER, default 16'hFFFF, meaning maximum SUB iterations before abort (used only with timeout feature).
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a division run; sampled in IDLE only.
REQ-006 SHALL have port cmp_ge  input  1  datapath flag: a0 >= sub.
REQ-007 SHALL have port sub_is_zero  input  1  datapath flag: sub == 0.
REQ-008 SHALL have ports CTRL1, CTRL2, CTRL6, CTRL7  output  1 each  CTRL1 load a0 from register_value; CTRL2 latch sub operand; CTRL6 write a0 <= a0 - sub; CTRL7 drive a0_out.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  run aborted; held until next accepted start.
REQ-012 SHALL have port quotient  output  QW  number of subtractions performed.

Function
REQ-013 SHALL implement Moore FSM with states IDLE, LOAD, CHECK, SUB, FIN, ABORT; CTRL outputs decoded from state only.
REQ-014 IDLE: start=1 -> LOAD, clear quotient and err; start=0 -> stay.
REQ-015 LOAD: CTRL1=1 and CTRL2=1 for exactly one cycle -> CHECK.
REQ-016 CHECK: sub_is_zero=1 -> ABORT (priority over cmp_ge); else cmp_ge=1 -> SUB; else -> FIN.
REQ-017 SUB: CTRL6=1 for one cycle, quotient += 1 -> CHECK.
REQ-018 FIN: CTRL7=1, done=1 for one cycle -> IDLE.
REQ-019 ABORT: err set, done=1 for one cycle -> IDLE; CTRL6 and CTRL7 stay 0.
REQ-020 Latency: start sampled at edge 0 gives FIN in cycle 2q+3 (q = final quotient).
REQ-021 At most one CTRL output high in any cycle except LOAD (CTRL1+CTRL2).
REQ-022 start while busy SHALL be ignored; start held high through FIN begins a new run in the cycle after FIN.
REQ-023 quotient and err SHALL hold their final values in IDLE until the next accepted start.
REQ-024 quotient SHALL never wrap; reaching 2^QW-1 in SUB forces ABORT on the next CHECK.

Reset
REQ-025 RST_N=0 SHALL asynchronously force state IDLE, quotient=0, err=0, done=0, busy=0, all CTRL=0, including mid-run.
REQ-026 After RST_N deassertion the first accepted start SHALL be no earlier than the next rising edge.

Configuration
REQ-027 Macro DATAPATH_CONTROL_TIMEOUT_EN defined: CHECK with quotient == MAX_ITER SHALL go to ABORT regardless of cmp_ge.
REQ-028 Macro DATAPATH_CONTROL_TIMEOUT_EN undefined: no iteration limit other than REQ-024; MAX_ITER unused.

Verification
REQ-029 Bench models datapath (a0=4620, sub=10), start pulse -> 462 CTRL6 pulses, quotient=462, done in cycle 927, err=0.
REQ-030 a0=7, sub=10 -> no CTRL6, quotient=0, FIN in cycle 3, CTRL7 high one cycle.
REQ-031 sub=0 -> ABORT from first CHECK, err=1, done pulse in cycle 3, quotient=0.
REQ-032 RST_N low during SUB at quotient=100 -> all outputs 0 immediately; new start completes normally.
REQ-033 With DATAPATH_CONTROL_TIMEOUT_EN, MAX_ITER=5, a0=4620, sub=10 -> quotient=5, err=1, done pulse.
REQ-034 start toggled during busy -> ignored; quotient and done timing identical to REQ-029.

Source files
------------

// File: rtl/datapath_control.sv
// datapath_control: sequencer for a repeated-subtract divider (load, compare, subtract, finish/abort); iteration cap via DATAPATH_CONTROL_TIMEOUT_EN.
// Latency: start accepted at edge 0 -> FIN (CTRL7 + done) in cycle 2q+3, q = final quotient; all outputs registered.
// Backpressure: none; start is sampled only in IDLE and ignored while busy.
module datapath_control #(
  parameter int          QW       = 16,
  parameter int unsigned MAX_ITER = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic          cmp_ge,
  input  logic          sub_is_zero,
  output logic          CTRL1,
  output logic          CTRL2,
  output logic          CTRL6,
  output logic          CTRL7,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [QW-1:0] quotient
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SUB   = 3'd3,
    FIN   = 3'd4,
    ABORT = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   iter_cap;

`ifdef DATAPATH_CONTROL_TIMEOUT_EN
  assign iter_cap = (quotient == QW'(MAX_ITER));
`else
  logic unused_max_iter;
  assign unused_max_iter = ^MAX_ITER;
  assign iter_cap        = 1'b0;
`endif

  // A full quotient counter aborts instead of taking another SUB, so it never wraps.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = CHECK;
      CHECK: begin
        if (sub_is_zero || (quotient == '1) || iter_cap) state_nxt = ABORT;
        else if (cmp_ge)                                   state_nxt = SUB;
        else                                               state_nxt = FIN;
      end
      SUB:     state_nxt = CHECK;
      FIN:     state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track the current state exactly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      CTRL1    <= 1'b0;
      CTRL2    <= 1'b0;
      CTRL6    <= 1'b0;
      CTRL7    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      quotient <= '0;
    end else begin
      state <= state_nxt;
      CTRL1 <= (state_nxt == LOAD);
      CTRL2 <= (state_nxt == LOAD);
      CTRL6 <= (state_nxt == SUB);
      CTRL7 <= (state_nxt == FIN);
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == FIN) || (state_nxt == ABORT);
      if (state == IDLE && start) begin
        quotient <= '0;
        err      <= 1'b0;
      end
      if (state == SUB) quotient <= quotient + 1'b1;
      if (state_nxt == ABORT) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_datapath_control.sv
// Bench for datapath_control: models the a0/sub datapath, issues directed runs and
// scores each completion (quotient, err, CTRL6/CTRL7 counts, done cycle) from a queue.
module tb_datapath_control;

  localparam int QW     = 10;
  localparam int BUDGET = 5000;
`ifdef DATAPATH_CONTROL_TIMEOUT_EN
  localparam int unsigned MI = 5;
  localparam int BIG_Q = 5;     // 4620/10 capped at MAX_ITER
  localparam bit BIG_E = 1'b1;
  localparam int SAT_Q = 5;
  localparam int RST_AT = 3;
`else
  localparam int unsigned MI = 16'hFFFF;
  localparam int BIG_Q = 462;
  localparam bit BIG_E = 1'b0;
  localparam int SAT_Q = 1023;  // 2^QW-1 saturation abort
  localparam int RST_AT = 100;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic          cmp_ge, sub_is_zero;
  logic          CTRL1, CTRL2, CTRL6, CTRL7, busy, done, err;
  logic [QW-1:0] quotient;

  datapath_control #(.QW(QW), .MAX_ITER(MI)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .cmp_ge(cmp_ge), .sub_is_zero(sub_is_zero),
    .CTRL1(CTRL1), .CTRL2(CTRL2), .CTRL6(CTRL6), .CTRL7(CTRL7),
    .busy(busy), .done(done), .err(err), .quotient(quotient)
  );

  always #5 CLK = ~CLK;

  // Datapath model: a0/sub registers driven by the control strobes.
  logic [15:0] a0 = '0, sub = '0, reg_val = '0, sub_val = '0;
  always @(posedge CLK) begin
    if (CTRL1) a0 <= reg_val;
    if (CTRL2) sub <= sub_val;
    if (CTRL6) a0 <= a0 - sub;
  end
  assign cmp_ge      = (a0 >= sub);
  assign sub_is_zero = (sub == 16'd0);

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int q;
    bit e;
    int dcyc;
    int id;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int n6 = 0, n7 = 0, viol = 0, runs_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: scores every done pulse against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        n6 = 0;
        n7 = 0;
      end else begin
        if (CTRL6) n6++;
        if (CTRL7) n7++;
        if (CTRL1 !== CTRL2) viol++;
        if ((int'(CTRL1) + int'(CTRL6) + int'(CTRL7)) > 1) viol++;
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            runs_seen++;
            $display("run %0d: quotient=%0d err=%0d ctrl6=%0d cyc=%0d", e.id, quotient, err, n6, cyc);
            chk($sformatf("run%0d_quotient", e.id), quotient, e.q);
            chk($sformatf("run%0d_err", e.id), err, e.e);
            chk($sformatf("run%0d_ctrl6_pulses", e.id), n6, e.q);
            chk($sformatf("run%0d_ctrl7_pulses", e.id), n7, e.e ? 0 : 1);
            chk($sformatf("run%0d_done_cycle", e.id), cyc, e.dcyc);
          end
          n6 = 0;
          n7 = 0;
        end
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; start is sampled on the next edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] s, input int q, input bit e, input int id);
    exp_t x;
    reg_val = a;
    sub_val = s;
    start   = 1'b1;
    x.q = q; x.e = e; x.id = id;
    x.dcyc = cyc + 1 + 2*q + 2;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < BUDGET) begin
      @(negedge CLK);
      t++;
    end
    chk(nm, (t < BUDGET), 1);
    exp_q.delete();
    repeat (2) @(negedge CLK);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] s, input int q, input bit e, input int id);
    issue(a, s, q, e, id);
    @(negedge CLK);
    start = 1'b0;
    wait_drain($sformatf("run%0d_finished", id));
  endtask

  initial begin
    int t;
    int s2;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {CTRL1, CTRL2, CTRL6, CTRL7, busy, done, err, quotient}, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_after_reset", {busy, done, quotient}, 0);

    run(16'd4620, 16'd10, BIG_Q, BIG_E, 1);
    repeat (4) @(negedge CLK);
    chk("hold_quotient_idle", quotient, BIG_Q);
    chk("hold_err_idle", err, BIG_E);
    chk("busy_low_idle", busy, 0);

    run(16'd7, 16'd10, 0, 1'b0, 2);
    run(16'd55, 16'd0, 0, 1'b1, 3);
    repeat (4) @(negedge CLK);
    chk("err_held_after_abort", err, 1);
    run(16'd30, 16'd10, 3, 1'b0, 4);

    // start toggled every cycle while busy: must not disturb the run
    issue(16'd4620, 16'd10, BIG_Q, BIG_E, 5);
    t = 0;
    forever begin
      @(negedge CLK);
      t++;
      if (done || t >= BUDGET) break;
      start = ~start;
    end
    start = 1'b0;
    wait_drain("run5_finished");

    // start held through FIN starts a second run two edges after the FIN cycle
    issue(16'd7, 16'd10, 0, 1'b0, 6);
    s2 = cyc + 1 + 2 + 2;
    begin
      exp_t x;
      x.q = 0; x.e = 1'b0; x.id = 7; x.dcyc = s2 + 2;
      exp_q.push_back(x);
    end
    t = 0;
    while (cyc < s2 && t < BUDGET) begin
      @(negedge CLK);
      t++;
    end
    start = 1'b0;
    wait_drain("run6_7_finished");

    run(16'd20000, 16'd10, SAT_Q, 1'b1, 8);

    // asynchronous reset in the middle of a SUB
    issue(16'd4620, 16'd10, BIG_Q, BIG_E, 9);
    @(negedge CLK);
    start = 1'b0;
    t = 0;
    while (!(CTRL6 && quotient == RST_AT) && t < BUDGET) begin
      @(negedge CLK);
      t++;
    end
    chk("reached_sub_before_reset", CTRL6, 1);
    #2 RST_N = 1'b0;
    #1 chk("midrun_reset_outputs", {CTRL1, CTRL2, CTRL6, CTRL7, busy, done, err, quotient}, 0);
    exp_q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    run(16'd40, 16'd10, 4, 1'b0, 10);

    chk("ctrl_exclusive_violations", viol, 0);
    chk("runs_completed", runs_seen, 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
